// File: rtl/m3_phase_step_if.sv
// m3 phase step generator bus: run controls in,
// step index, round pulse and gate enables out.
interface m3_phase_step_if;
  logic        working;
  logic        force_stop;
  logic        inv_rotate;
  logic [31:0] round_len;
  logic        next_round;
  logic [2:0]  step_idx;
  logic [5:0]  gate;

  modport master (
    output working, force_stop,
    output inv_rotate, round_len,
    input  next_round, step_idx, gate
  );

  modport slave (
    input  working, force_stop,
    input  inv_rotate, round_len,
    output next_round, step_idx, gate
  );
endinterface

// File: rtl/m3_phase_step_gen.sv
// 6-step commutation generator with dead time
// and a once-per-electrical-round pulse.
module m3_phase_step_gen #(
  parameter int unsigned PERIOD_MIN = 40,
  parameter int unsigned PERIOD_MAX = 4000000,
  parameter int unsigned DEAD_CYC   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  m3_phase_step_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    DRIVE
  } state_t;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [2:0]  rnd, rnd_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] per, per_n;
  logic [5:0]  gate, gate_n;
  logic        pulse, pulse_n;
  logic [31:0] len_c;

  function automatic logic [5:0] tbl(
    input logic [2:0] i
  );
    logic [5:0] g;
    g = 6'b000000;
    case (i)
      3'd0:    g = 6'b100100;
      3'd1:    g = 6'b100001;
      3'd2:    g = 6'b001001;
      3'd3:    g = 6'b011000;
      3'd4:    g = 6'b010010;
      3'd5:    g = 6'b000110;
      default: g = 6'b000000;
    endcase
    return g;
  endfunction

  always_comb begin
    len_c = bus.round_len;
    if (bus.round_len < PERIOD_MIN)
      len_c = PERIOD_MIN;
    else if (bus.round_len > PERIOD_MAX)
      len_c = PERIOD_MAX;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    rnd_n   = rnd;
    cnt_n   = cnt;
    per_n   = per;
    pulse_n = 1'b0;
    if (bus.force_stop || !bus.working) begin
      state_n = IDLE;
      idx_n   = 3'd0;
      rnd_n   = 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = DEAD;
          idx_n   = 3'd0;
          per_n   = len_c;
          cnt_n   = len_c - 32'd1;
        end
        DEAD: begin
          cnt_n = cnt - 32'd1;
          // cnt started at per-1, so this is the last dead clock
          if (cnt == per - DEAD_CYC)
            state_n = DRIVE;
        end
        DRIVE: begin
          if (cnt == 32'd0) begin
            state_n = DEAD;
            per_n   = len_c;
            cnt_n   = len_c - 32'd1;
            if (bus.inv_rotate)
              idx_n = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
            else
              idx_n = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            if (rnd == 3'd5) begin
              rnd_n   = 3'd0;
              pulse_n = 1'b1;
            end else begin
              rnd_n = rnd + 3'd1;
            end
          end else begin
            cnt_n = cnt - 32'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    gate_n = (state_n == DRIVE) ? tbl(idx_n) : 6'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 3'd0;
      rnd   <= 3'd0;
      cnt   <= 32'd0;
      per   <= PERIOD_MAX;
      gate  <= 6'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      rnd   <= rnd_n;
      cnt   <= cnt_n;
      per   <= per_n;
      gate  <= gate_n;
      pulse <= pulse_n;
    end
  end

  assign bus.gate       = gate;
  assign bus.step_idx   = idx;
  assign bus.next_round = pulse;
endmodule

// File: tb/tb_m3_phase_step_gen.sv
// Directed bench for m3_phase_step_gen, with a
// short randomised run checking gate safety.
module tb_m3_phase_step_gen;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [5:0] g_tr [0:1023];
  logic [2:0] s_tr [0:1023];
  logic       n_tr [0:1023];

  m3_phase_step_if bus ();

  m3_phase_step_gen #(
    .PERIOD_MIN (40),
    .PERIOD_MAX (300),
    .DEAD_CYC   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic cap(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g_tr[base+i] = bus.gate;
      s_tr[base+i] = bus.step_idx;
      n_tr[base+i] = bus.next_round;
    end
  endtask

  task automatic start(
    input logic [31:0] len,
    input logic        inv
  );
    bus.round_len  = len;
    bus.inv_rotate = inv;
    bus.working    = 1'b1;
  endtask

  task automatic halt();
    bus.working = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic int unsafe_cnt(input int n);
    int b;
    b = 0;
    for (int i = 0; i < n; i++)
      if ((g_tr[i][5] & g_tr[i][4]) |
          (g_tr[i][3] & g_tr[i][2]) |
          (g_tr[i][1] & g_tr[i][0]))
        b++;
    return b;
  endfunction

  initial begin
    int z, d, np, fp;
    int bnd, pls, bad;
    logic [2:0] prev;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.working    = 1'b1;
    bus.force_stop = 1'b0;
    bus.inv_rotate = 1'b0;
    bus.round_len  = 32'd100;
    repeat (3) @(negedge clk);
    chk("rst_gate", 32'(bus.gate), 32'd0);
    chk("rst_step", 32'(bus.step_idx), 32'd0);
    chk("rst_nr", 32'(bus.next_round), 32'd0);
    bus.working = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // forward run, period 100
    start(32'd100, 1'b0);
    cap(0, 610);
    z = 0;
    d = 0;
    for (int i = 0; i < 100; i++) begin
      if (g_tr[i] == 6'b0) z++;
      if (g_tr[i] == 6'b100100) d++;
    end
    chk("t1_dead_n", 32'(z), 32'd8);
    chk("t1_drv_n", 32'(d), 32'd92);
    chk("t1_g7", 32'(g_tr[7]), 32'h00);
    chk("t1_g8", 32'(g_tr[8]), 32'b100100);
    chk("t1_g100", 32'(g_tr[100]), 32'h00);
    chk("t1_g108", 32'(g_tr[108]), 32'b100001);
    chk("t1_g208", 32'(g_tr[208]), 32'b001001);
    chk("t1_g308", 32'(g_tr[308]), 32'b011000);
    chk("t1_g408", 32'(g_tr[408]), 32'b010010);
    chk("t1_g508", 32'(g_tr[508]), 32'b000110);
    chk("t1_s99", 32'(s_tr[99]), 32'd0);
    chk("t1_s100", 32'(s_tr[100]), 32'd1);
    chk("t1_s599", 32'(s_tr[599]), 32'd5);
    chk("t1_s600", 32'(s_tr[600]), 32'd0);
    np = 0;
    fp = -1;
    for (int i = 0; i < 610; i++)
      if (n_tr[i]) begin
        np++;
        if (fp < 0) fp = i;
      end
    chk("t1_nr_cnt", 32'(np), 32'd1);
    chk("t1_nr_pos", 32'(fp), 32'd600);
    chk("t1_safe", 32'(unsafe_cnt(610)), 32'd0);
    bus.working = 1'b0;
    @(negedge clk);
    chk("t1_stop_g", 32'(bus.gate), 32'd0);
    chk("t1_stop_s", 32'(bus.step_idx), 32'd0);
    @(negedge clk);

    // clamp up to 40
    start(32'd10, 1'b0);
    cap(0, 90);
    chk("t2_s39", 32'(s_tr[39]), 32'd0);
    chk("t2_s40", 32'(s_tr[40]), 32'd1);
    chk("t2_g39", 32'(g_tr[39]), 32'b100100);
    chk("t2_g40", 32'(g_tr[40]), 32'h00);
    chk("t2_g48", 32'(g_tr[48]), 32'b100001);
    halt();

    // clamp down to PERIOD_MAX=300
    start(32'hFFFF_FFFF, 1'b0);
    cap(0, 310);
    chk("t2_s299", 32'(s_tr[299]), 32'd0);
    chk("t2_s300", 32'(s_tr[300]), 32'd1);
    chk("t2_g299", 32'(g_tr[299]), 32'b100100);
    halt();

    // reverse from start
    start(32'd40, 1'b1);
    cap(0, 250);
    chk("t3_s40", 32'(s_tr[40]), 32'd5);
    chk("t3_s80", 32'(s_tr[80]), 32'd4);
    chk("t3_s120", 32'(s_tr[120]), 32'd3);
    chk("t3_s160", 32'(s_tr[160]), 32'd2);
    chk("t3_s200", 32'(s_tr[200]), 32'd1);
    chk("t3_s240", 32'(s_tr[240]), 32'd0);
    chk("t3_g48", 32'(g_tr[48]), 32'b000110);
    chk("t3_nr240", 32'(n_tr[240]), 32'd1);
    halt();

    // reverse requested mid step 2
    start(32'd40, 1'b0);
    cap(0, 100);
    bus.inv_rotate = 1'b1;
    cap(100, 150);
    chk("t3_t119", 32'(s_tr[119]), 32'd2);
    chk("t3_t120", 32'(s_tr[120]), 32'd1);
    chk("t3_t160", 32'(s_tr[160]), 32'd0);
    chk("t3_t200", 32'(s_tr[200]), 32'd5);
    chk("t3_tnr", 32'(n_tr[240]), 32'd1);
    halt();

    // force stop mid DRIVE of step 1
    start(32'd100, 1'b0);
    cap(0, 150);
    chk("t4_pre_g", 32'(g_tr[149]), 32'b100001);
    bus.force_stop = 1'b1;
    cap(150, 1);
    chk("t4_g", 32'(g_tr[150]), 32'd0);
    chk("t4_s", 32'(s_tr[150]), 32'd0);
    chk("t4_nr", 32'(n_tr[150]), 32'd0);
    cap(151, 3);
    chk("t4_hold", 32'(g_tr[153]), 32'd0);
    bus.force_stop = 1'b0;
    cap(0, 610);
    chk("t4_r_g7", 32'(g_tr[7]), 32'd0);
    chk("t4_r_g8", 32'(g_tr[8]), 32'b100100);
    chk("t4_r_s0", 32'(s_tr[0]), 32'd0);
    chk("t4_r_nr500", 32'(n_tr[500]), 32'd0);
    chk("t4_r_nr600", 32'(n_tr[600]), 32'd1);
    halt();

    // period change mid step 3
    start(32'd100, 1'b0);
    cap(0, 350);
    bus.round_len = 32'd60;
    cap(350, 150);
    chk("t5_s399", 32'(s_tr[399]), 32'd3);
    chk("t5_s400", 32'(s_tr[400]), 32'd4);
    chk("t5_g407", 32'(g_tr[407]), 32'd0);
    chk("t5_g408", 32'(g_tr[408]), 32'b010010);
    chk("t5_s459", 32'(s_tr[459]), 32'd4);
    chk("t5_s460", 32'(s_tr[460]), 32'd5);
    chk("t5_safe", 32'(unsafe_cnt(500)), 32'd0);
    halt();

    // random periods and direction
    start(32'd50, 1'b0);
    bnd = 0;
    pls = 0;
    bad = 0;
    prev = 3'd0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ((bus.gate[5] & bus.gate[4]) |
          (bus.gate[3] & bus.gate[2]) |
          (bus.gate[1] & bus.gate[0]))
        bad++;
      if (bus.step_idx != prev) begin
        bnd++;
        if (bus.gate != 6'b0) bad++;
      end
      if (bus.next_round) pls++;
      prev = bus.step_idx;
      if ($urandom_range(0, 49) == 0) begin
        bus.round_len  = $urandom_range(20, 90);
        bus.inv_rotate = 1'($urandom_range(0, 1));
      end
    end
    chk("t6_safe", 32'(bad), 32'd0);
    chk("t6_rounds", 32'(pls), 32'(bnd / 6));
    halt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
